// File: rtl/shift_frame_tx.sv
// Start/8-data/stop serializer with a ready/valid word input and selectable shift direction.
// Define SHIFT_FRAME_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module shift_frame_tx #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_msb_first,
  output logic       ser_out,
  output logic       ser_active,
  output logic       frame_done
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam logic [7:0] LAST_TICK = 8'(CLKS_PER_BIT - 1);

  state_t     r_state;
  state_t     w_nextState;
  logic [7:0] r_tickCnt;
  logic [2:0] r_bitIdx;
  logic [7:0] r_shift;
  logic       r_msbFirst;
  logic       w_bitEnd;
  logic       w_transfer;
`ifdef SHIFT_FRAME_TX_PARITY_EN
  logic       r_parity;
`endif

  assign w_bitEnd   = (r_tickCnt == LAST_TICK);
  assign w_transfer = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:  if (w_transfer) w_nextState = START;
      START: if (w_bitEnd) w_nextState = DATA;
      DATA: begin
        if (w_bitEnd && (r_bitIdx == 3'd7)) begin
`ifdef SHIFT_FRAME_TX_PARITY_EN
          w_nextState = PARITY;
`else
          w_nextState = STOP;
`endif
        end
      end
`ifdef SHIFT_FRAME_TX_PARITY_EN
      PARITY: if (w_bitEnd) w_nextState = STOP;
`endif
      STOP:  if (w_bitEnd) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // The word, direction and parity are captured only at the transfer; the
  // bit-period counter reloads at every bit boundary while a frame is running.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tickCnt  <= '0;
      r_bitIdx   <= '0;
      r_shift    <= '0;
      r_msbFirst <= 1'b0;
`ifdef SHIFT_FRAME_TX_PARITY_EN
      r_parity   <= 1'b0;
`endif
    end else if (r_state == IDLE) begin
      r_tickCnt <= '0;
      r_bitIdx  <= '0;
      if (w_transfer) begin
        r_shift    <= in_data;
        r_msbFirst <= in_msb_first;
`ifdef SHIFT_FRAME_TX_PARITY_EN
        r_parity   <= ^in_data;
`endif
      end
    end else begin
      r_tickCnt <= w_bitEnd ? 8'd0 : r_tickCnt + 8'd1;
      if ((r_state == DATA) && w_bitEnd) begin
        r_bitIdx <= r_bitIdx + 3'd1;
        r_shift  <= r_msbFirst ? {r_shift[6:0], 1'b0} : {1'b0, r_shift[7:1]};
      end
    end
  end

  always_comb begin
    ser_out    = 1'b1;
    ser_active = 1'b1;
    frame_done = 1'b0;
    in_ready   = 1'b0;
    case (r_state)
      IDLE: begin
        ser_active = 1'b0;
        in_ready   = !rst;
      end
      START: ser_out = 1'b0;
      DATA:  ser_out = r_msbFirst ? r_shift[7] : r_shift[0];
`ifdef SHIFT_FRAME_TX_PARITY_EN
      PARITY: ser_out = r_parity;
`endif
      STOP:  frame_done = w_bitEnd && !rst;
      default: ser_active = 1'b0;
    endcase
  end

endmodule

// File: doc/shift_frame_tx.md
SHIFT_FRAME_TX -- requirements
Module: shift_frame_tx

Interface
REQ-001 SHALL provide parameter: CLKS_PER_BIT, default 4, clock cycles per serial bit (legal range 1..255).
REQ-002 SHALL provide port: clk  input  1  rising-edge clock for all state.
REQ-003 SHALL provide port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL provide port: in_valid  input  1  upstream word offered.
REQ-005 SHALL provide port: in_ready  output  1  block can accept a word this cycle.
REQ-006 SHALL provide port: in_data  input  8  parallel word to serialize.
REQ-007 SHALL provide port: in_msb_first  input  1  1 = shift MSB first (left shift), 0 = LSB first (right shift); sampled with in_data.
REQ-008 SHALL provide port: ser_out  output  1  serial line, idle level 1.
REQ-009 SHALL provide port: ser_active  output  1  high while a frame is on the line.
REQ-010 SHALL provide port: frame_done  output  1  one-cycle pulse marking the end of a frame.

Function
REQ-011 SHALL implement states IDLE, START, DATA, PARITY, STOP; PARITY is reachable only when the configuration macro is defined.
REQ-012 SHALL assert in_ready only in IDLE; a transfer occurs on a rising edge where in_valid and in_ready are both 1.
REQ-013 SHALL, on transfer, latch in_data into an 8-bit shift register and latch in_msb_first, and enter START on the next cycle.
REQ-014 SHALL ignore in_valid and in_data and hold the latched word while not in IDLE.
REQ-015 SHALL hold each bit on ser_out for exactly CLKS_PER_BIT cycles using a bit-period counter that reloads at each bit boundary.
REQ-016 SHALL drive ser_out = 0 in START.
REQ-017 SHALL send 8 data bits in DATA, counted by a 3-bit index that wraps 7->0 on leaving DATA.
REQ-018 SHALL, in DATA, send bit 7 first when MSB-first and shift the register left by 1; when LSB-first, send bit 0 first and shift right by 1.
REQ-019 SHALL drive ser_out = 1 in STOP and in IDLE.
REQ-020 SHALL assert ser_active in START, DATA, PARITY and STOP, and deassert it in IDLE.
REQ-021 SHALL pulse frame_done during the last cycle of STOP and return to IDLE on the following edge (in_ready = 1 that cycle).
REQ-022 SHALL make the frame length 10*CLKS_PER_BIT cycles, or 11*CLKS_PER_BIT with parity, from the first START cycle to the last STOP cycle inclusive.
REQ-023 SHALL, with CLKS_PER_BIT = 1, change bit on every cycle with no idle gaps inside a frame.
REQ-024 SHALL not overlap frames; the minimum gap between frames is one IDLE cycle.

Reset
REQ-025 SHALL, while rst = 1 on a clock edge, force state IDLE, shift register 0, counters 0, ser_out 1, ser_active 0, frame_done 0 and in_ready 0.
REQ-026 SHALL drive in_ready = 1 in the first cycle after rst is released.
REQ-027 SHALL abort a frame in progress when rst is asserted mid-frame, with no frame_done pulse, and ser_out = 1 from the following cycle.
REQ-028 SHALL give rst priority over a simultaneous transfer.

Configuration
REQ-029 SHALL, when SHIFT_FRAME_TX_PARITY_EN is defined, insert a PARITY bit between DATA and STOP whose value is the even parity (XOR) of the 8 latched data bits, held for CLKS_PER_BIT cycles.
REQ-030 SHALL, when SHIFT_FRAME_TX_PARITY_EN is undefined, go from DATA directly to STOP, and shall contain no parity logic.

Verification
REQ-031 SHALL test: CLKS_PER_BIT=2, 8'hA5, MSB-first -> ser_out 0,1,0,1,0,0,1,0,1,1, each held 2 cycles; frame_done in cycle 20 after START begins.
REQ-032 SHALL test: CLKS_PER_BIT=1, 8'h01, LSB-first -> ser_out 0,1,0,0,0,0,0,0,0,1; in_ready 0 for 10 cycles, then 1.
REQ-033 SHALL test: in_valid held high with 8'hFF then 8'h00 back-to-back -> second word accepted only after frame_done, with exactly one IDLE cycle between frames.
REQ-034 SHALL test: with parity enabled, 8'hA5 -> parity bit 0; 8'h07 -> parity bit 1; frame of 11 bits.
REQ-035 SHALL test: rst asserted in DATA bit 4 -> ser_out 1 next cycle, no frame_done, in_ready 1 the cycle after rst is released.
REQ-036 SHALL test: in_data changed mid-frame with in_valid=1 -> serialized bits unchanged.
